// File: rtl/instruction_loader_pkg.sv
// Shared CPU definitions for the serial program loader: loader FSM encoding, memory geometry
// defaults and the program-header width.
package instruction_loader_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DEPTH_DEF  = 1024;
   localparam int unsigned HDR_W      = 16;

   typedef enum logic [2:0] {
      StIdle,
      StHdrLo,
      StHdrHi,
      StData,
      StDone,
      StErr
   } state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs serial bytes into big-endian 32-bit words. It flags the byte that completes a word
// combinationally so the caller can register the write on the same clock edge.
module word_assembler (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_ready,
   output logic [31:0] o_word
);

   logic [1:0]  r_idx;
   logic [23:0] r_shift;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_clear) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_valid) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= {r_shift[15:0], i_byte};
      end
   end

   // The fourth byte is still on the input, so the word is only complete in combination.
   assign o_word_ready = i_valid && !i_clear && (r_idx == 2'd3);
   assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream: a 16-bit little-endian word
// count, then that many big-endian 32-bit words. Holds fetch until a complete load.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_fetch_hold,
   output logic              o_load_done,
   output logic              o_error
);

   state_e             r_state, w_state_d;
   logic [HDR_W-1:0]   r_count, w_count_d;
   logic [HDR_W-1:0]   r_word_idx, w_word_idx_d;
   logic               r_we, w_we_d;
   logic [ADDR_W-1:0]  r_addr, w_addr_d;
   logic [31:0]        r_wdata, w_wdata_d;
   logic               r_hold, w_hold_d;
   logic               r_done, w_done_d;
   logic               r_err, w_err_d;

   logic               w_asm_valid;
   logic               w_word_ready;
   logic [31:0]        w_word;
   logic [HDR_W-1:0]   w_hdr;
   logic               w_hdr_bad;
   logic               w_all_written;

   assign w_hdr         = {i_rx_data, r_count[7:0]};
   assign w_hdr_bad     = (w_hdr == '0) || (32'(w_hdr) > DEPTH);
   assign w_all_written = (r_word_idx == r_count);
   // Bytes arriving after the last word are ignored rather than started as a new word.
   assign w_asm_valid   = i_rx_valid && !i_start && (r_state == StData) && !w_all_written;

   word_assembler u_word_assembler (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (i_start),
      .i_valid      (w_asm_valid),
      .i_byte       (i_rx_data),
      .o_word_ready (w_word_ready),
      .o_word       (w_word)
   );

   always_comb begin
      w_state_d    = r_state;
      w_count_d    = r_count;
      w_word_idx_d = r_word_idx;
      w_we_d       = 1'b0;
      w_addr_d     = r_addr;
      w_wdata_d    = r_wdata;
      w_hold_d     = r_hold;
      w_done_d     = 1'b0;
      w_err_d      = r_err;

      if (i_start) begin
         w_state_d    = StHdrLo;
         w_count_d    = '0;
         w_word_idx_d = '0;
         w_hold_d     = 1'b1;
         w_err_d      = 1'b0;
      end else begin
         case (r_state)
            StHdrLo: begin
               if (i_rx_valid) begin
                  w_count_d = {8'd0, i_rx_data};
                  w_state_d = StHdrHi;
               end
            end
            StHdrHi: begin
               if (i_rx_valid) begin
                  w_count_d    = w_hdr;
                  w_word_idx_d = '0;
                  if (w_hdr_bad) begin
                     w_state_d = StErr;
                     w_err_d   = 1'b1;
                  end else begin
                     w_state_d = StData;
                  end
               end
            end
            StData: begin
               if (w_all_written) begin
                  w_state_d = StDone;
                  w_done_d  = 1'b1;
                  w_hold_d  = 1'b0;
               end else if (w_word_ready) begin
                  w_we_d       = 1'b1;
                  w_addr_d     = r_word_idx[ADDR_W-1:0];
                  w_wdata_d    = w_word;
                  w_word_idx_d = r_word_idx + 1'b1;
               end
            end
            StDone:  w_state_d = StIdle;
            StIdle:  w_state_d = StIdle;
            StErr:   w_state_d = StErr;
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_count    <= '0;
         r_word_idx <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_count    <= w_count_d;
         r_word_idx <= w_word_idx_d;
         r_we       <= w_we_d;
         r_addr     <= w_addr_d;
         r_wdata    <= w_wdata_d;
         r_hold     <= w_hold_d;
         r_done     <= w_done_d;
         r_err      <= w_err_d;
      end
   end

   assign o_imem_we    = r_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = r_wdata;
   assign o_fetch_hold = r_hold;
   assign o_load_done  = r_done;
   assign o_error      = r_err;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: reset behaviour, normal loads, header errors,
// full-depth load, restart and reset in the middle of a load.
module tb_instruction_loader;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          fetch_hold;
   logic          load_done;
   logic          error;

   int n_pass  = 0;
   int n_total = 0;
   int n_done  = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   instruction_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_fetch_hold (fetch_hold),
      .o_load_done  (load_done),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
      if (load_done) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int base;
   int bad;
   int zero_hits;
   int dones0;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      idle(3);
      check("rst_fetch_hold", 32'(fetch_hold), 32'd1);
      check("rst_we",         32'(imem_we),    32'd0);
      check("rst_load_done",  32'(load_done),  32'd0);
      check("rst_error",      32'(error),      32'd0);
      check("rst_addr",       32'(imem_addr),  32'd0);
      check("rst_wdata",      imem_wdata,      32'd0);

      // No start after reset: bytes are ignored, nothing written.
      rst_n = 1'b1;
      send(8'h01);
      send(8'h00);
      idle(1000);
      check("nostart_writes", 32'(wr_addr.size()), 32'd0);
      check("nostart_hold",   32'(fetch_hold),     32'd1);

      // Two-word load.
      pulse_start();
      send(8'h02); send(8'h00);
      send_word(32'h2008_0005);
      send_word(32'hAC01_0004);
      check("w2_we_timing", 32'(imem_we),   32'd1);
      check("w2_addr_live", 32'(imem_addr), 32'd1);
      @(negedge clk);
      check("w2_done_pulse", 32'(load_done),  32'd1);
      check("w2_hold_drop",  32'(fetch_hold), 32'd0);
      idle(5);
      check("w2_nwrites", 32'(wr_addr.size()), 32'd2);
      check("w2_addr0",   32'(wr_addr[0]),     32'd0);
      check("w2_data0",   wr_data[0],          32'h2008_0005);
      check("w2_addr1",   32'(wr_addr[1]),     32'd1);
      check("w2_data1",   wr_data[1],          32'hAC01_0004);
      check("w2_ndone",   32'(n_done),         32'd1);
      check("w2_hold_idle", 32'(fetch_hold),   32'd0);
      check("w2_addr_hold", 32'(imem_addr),    32'd1);
      check("w2_wdata_hold", imem_wdata,       32'hAC01_0004);

      // Zero-length header errors; a new start clears the flag.
      base = wr_addr.size();
      pulse_start();
      check("z_hold_after_start", 32'(fetch_hold), 32'd1);
      send(8'h00); send(8'h00);
      check("z_error", 32'(error), 32'd1);
      send_word(32'h1122_3344);
      idle(3);
      check("z_error_sticky", 32'(error),      32'd1);
      check("z_hold",         32'(fetch_hold), 32'd1);
      check("z_nowrite", 32'(wr_addr.size() - base), 32'd0);
      pulse_start();
      check("z_error_clear", 32'(error), 32'd0);

      // Count 1025 exceeds depth.
      pulse_start();
      send(8'h01); send(8'h04);
      check("ovf_error", 32'(error), 32'd1);

      // Full-depth load of 1024 words.
      base   = wr_addr.size();
      dones0 = n_done;
      pulse_start();
      send(8'h00); send(8'h04);
      check("full_no_error", 32'(error), 32'd0);
      for (int i = 0; i < 1024; i++) send_word(32'hC0DE_0000 | 32'(i));
      idle(4);
      check("full_nwrites", 32'(wr_addr.size() - base), 32'd1024);
      bad       = 0;
      zero_hits = 0;
      for (int k = 0; k < wr_addr.size() - base; k++) begin
         if (wr_addr[base + k] !== AW'(k) || wr_data[base + k] !== (32'hC0DE_0000 | 32'(k)))
            bad++;
         if (wr_addr[base + k] === '0) zero_hits++;
      end
      check("full_seq_bad",   32'(bad),       32'd0);
      check("full_addr0_once", 32'(zero_hits), 32'd1);
      check("full_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'd1023);
      check("full_done",      32'(n_done - dones0), 32'd1);
      check("full_hold",      32'(fetch_hold), 32'd0);

      // Restart mid-word: partial bytes must not leak into the next load.
      pulse_start();
      send(8'h02); send(8'h00);
      send_word(32'hDEAD_BEEF);
      send(8'h99); send(8'h88);
      base = wr_addr.size();
      pulse_start();
      send(8'h01); send(8'h00);
      send_word(32'h1234_5678);
      idle(4);
      check("rs_nwrites", 32'(wr_addr.size() - base), 32'd1);
      check("rs_addr",    32'(wr_addr[base]),         32'd0);
      check("rs_data",    wr_data[base],              32'h1234_5678);

      // Start coincident with a byte: the byte is dropped, not taken as header.
      base = wr_addr.size();
      @(negedge clk);
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h05;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      send(8'h01); send(8'h00);
      send_word(32'hAABB_CCDD);
      idle(4);
      check("co_nwrites", 32'(wr_addr.size() - base), 32'd1);
      check("co_data",    wr_data[base],              32'hAABB_CCDD);

      // Reset mid-DATA with a partial word pending.
      pulse_start();
      send(8'h02); send(8'h00);
      send_word(32'h0102_0304);
      send(8'h11); send(8'h22);
      base = wr_addr.size();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_hold",  32'(fetch_hold), 32'd1);
      check("mr_we",    32'(imem_we),    32'd0);
      check("mr_addr",  32'(imem_addr),  32'd0);
      check("mr_wdata", imem_wdata,      32'd0);
      idle(2);
      rst_n = 1'b1;
      send(8'h33); send(8'h44);
      send_word(32'h5566_7788);
      idle(5);
      check("mr_nowrite", 32'(wr_addr.size() - base), 32'd0);
      check("mr_hold_after", 32'(fetch_hold), 32'd1);
      check("mr_error", 32'(error), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
